// File: rtl/baud_pkg.sv
// Shared widths, reset divisor and divisor record for the baud-rate tick generator.
package baud_pkg;
    localparam int BAUD_CNT_W      = 16;
    localparam int BAUD_FRAC_W     = 4;
    localparam int BAUD_OVERSAMPLE = 16;
    localparam int BAUD_DEF_INT    = 27;
    localparam int BAUD_DEF_FRAC   = 2;
    localparam int MIN_DIV         = 2;

    typedef struct packed {
        logic [BAUD_CNT_W-1:0]  int_part;
        logic [BAUD_FRAC_W-1:0] frac_part;
    } baud_div_t;

    function automatic logic div_legal(input logic [BAUD_CNT_W-1:0] value);
        return value >= BAUD_CNT_W'(MIN_DIV);
    endfunction
endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: each step adds the fraction and registers the carry-out,
// which stretches the following period by one cycle. Built only under BAUD_GEN_FRAC_EN.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = BAUD_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);
    logic [FRAC_W-1:0] facc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, facc} + {1'b0, frac};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            facc  <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            facc  <= '0;
            carry <= 1'b0;
        end else if (step) begin
            facc  <= sum[FRAC_W-1:0];
            carry <= sum[FRAC_W];
        end
    end
endmodule

// File: rtl/baud_gen.sv
// Programmable baud tick generator with integer (+ optional fractional) divisor,
// oversample/bit strobes and bit-rate square wave. Fractional part: define BAUD_GEN_FRAC_EN.
module baud_gen
    import baud_pkg::*;
#(
    parameter int CNT_W      = BAUD_CNT_W,
    parameter int FRAC_W     = BAUD_FRAC_W,
    parameter int OVERSAMPLE = BAUD_OVERSAMPLE,
    parameter int DEF_INT    = BAUD_DEF_INT,
    parameter int DEF_FRAC   = BAUD_DEF_FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              phase_clr,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_err,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              clk_out
);
    localparam int OS_W = $clog2(OVERSAMPLE);

    baud_div_t        act;
    baud_div_t        shad;
    baud_div_t        new_div;
    logic             pend_vld;
    logic             load_ok;
    logic             wrap;
    logic             carry;
    logic             os_last;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W:0]   plen_m1;
    logic [OS_W-1:0]  oscnt;
    logic [OS_W-1:0]  oscnt_nxt;

    assign load_ok = div_load && div_legal(div_int);

`ifdef BAUD_GEN_FRAC_EN
    localparam baud_div_t DEF_DIV = '{int_part: CNT_W'(DEF_INT), frac_part: FRAC_W'(DEF_FRAC)};

    assign new_div = '{int_part: div_int, frac_part: div_frac};

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_clr),
        .step  (wrap),
        .frac  (act.frac_part),
        .carry (carry)
    );
`else
    localparam baud_div_t DEF_DIV = '{int_part: CNT_W'(DEF_INT), frac_part: '0};

    logic unused_frac;

    assign new_div     = '{int_part: div_int, frac_part: '0};
    assign carry       = 1'b0;
    assign unused_frac = ^{div_frac, act.frac_part, shad.frac_part, FRAC_W'(DEF_FRAC)};
`endif

    // Period length is the active integer divisor, stretched by one when the accumulator carried.
    assign plen_m1   = {1'b0, act.int_part} + {{CNT_W{1'b0}}, carry} - (CNT_W+1)'(1);
    assign wrap      = en && ({1'b0, pcnt} == plen_m1);
    assign os_last   = (oscnt == OS_W'(OVERSAMPLE - 1));
    assign oscnt_nxt = os_last ? '0 : oscnt + OS_W'(1);

    // A pending divisor only replaces the active one at a period boundary or a phase clear,
    // so the running period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act      <= DEF_DIV;
            shad     <= DEF_DIV;
            pend_vld <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_err <= div_load && !load_ok;
            if (phase_clr) begin
                if (load_ok) begin
                    act  <= new_div;
                    shad <= new_div;
                end else if (pend_vld) begin
                    act <= shad;
                end
                pend_vld <= 1'b0;
            end else begin
                if (wrap && pend_vld)
                    act <= shad;
                if (load_ok) begin
                    shad     <= new_div;
                    pend_vld <= 1'b1;
                end else if (wrap) begin
                    pend_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt     <= '0;
            oscnt    <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            clk_out  <= 1'b0;
        end else if (phase_clr) begin
            pcnt     <= '0;
            oscnt    <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            tick_os  <= wrap;
            tick_bit <= wrap && os_last;
            if (wrap) begin
                pcnt    <= '0;
                oscnt   <= oscnt_nxt;
                clk_out <= (oscnt_nxt >= OS_W'(OVERSAMPLE / 2));
            end else if (en) begin
                pcnt <= pcnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen: a per-cycle vector table on a divisor of 2,
// then hand-written interval sequences for defaults, loads, phase clear and enable freeze.
module tb_baud_gen;
    import baud_pkg::*;

`ifdef BAUD_GEN_FRAC_EN
    localparam int FRAC_ON = 1;
`else
    localparam int FRAC_ON = 0;
`endif

    typedef struct {
        bit          en;
        bit          phase_clr;
        bit          div_load;
        logic [15:0] div_int;
        logic [3:0]  div_frac;
        bit          exp_tick_os;
        bit          exp_tick_bit;
        bit          exp_clk_out;
        bit          exp_div_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        div_err;
    logic        tick_os;
    logic        tick_bit;
    logic        clk_out;

    int tests = 0;
    int failures = 0;
    vec_t vecs[19];

    baud_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .div_load  (div_load),
        .div_err   (div_err),
        .tick_os   (tick_os),
        .tick_bit  (tick_bit),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        en        = v.en;
        phase_clr = v.phase_clr;
        div_load  = v.div_load;
        div_int   = v.div_int;
        div_frac  = v.div_frac;
        stepCycle();
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        div_load  = 1'b0;
        div_int   = '0;
        div_frac  = '0;
        stepCycle();
        stepCycle();
        checkOutput("reset tick_os", tick_os, 0);
        checkOutput("reset tick_bit", tick_bit, 0);
        checkOutput("reset clk_out", clk_out, 0);
        checkOutput("reset div_err", div_err, 0);
        rst_n = 1'b1;
    endtask

    task automatic waitTick(input int budget, output int cycles);
        cycles = 0;
        do begin
            stepCycle();
            cycles++;
        end while (tick_os !== 1'b1 && cycles < budget);
        if (tick_os !== 1'b1) begin
            tests++;
            failures++;
            $display("[TB] FAIL tick_os timeout: got none in %0d cycles, expected a strobe", budget);
        end
    endtask

    // Length of period p (1-based) after a fresh start: integer divisor plus the carry
    // produced by the accumulator at wrap p-1.
    function automatic int expPeriod(input int p, input int frac, input int dint);
        if (FRAC_ON == 0 || p < 2)
            return dint;
        return dint + (frac * (p - 1)) / 16 - (frac * (p - 2)) / 16;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int first_os;
        int first_bit;
        int cnt;
        int total;
        bit seen;

        // en, clr, load, int, frac | tick_os, tick_bit, clk_out, div_err
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        resetDut();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec %0d tick_os", i), tick_os, vecs[i].exp_tick_os);
            checkOutput($sformatf("vec %0d tick_bit", i), tick_bit, vecs[i].exp_tick_bit);
            checkOutput($sformatf("vec %0d clk_out", i), clk_out, vecs[i].exp_clk_out);
            checkOutput($sformatf("vec %0d div_err", i), div_err, vecs[i].exp_div_err);
        end

        // Reset defaults: first strobe on cycle 27, carry pattern, bit strobe and square wave.
        resetDut();
        en = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            waitTick(100, cyc);
            checkOutput($sformatf("default period %0d", n), cyc, expPeriod(n, 2, 27));
            checkOutput($sformatf("default tick_bit %0d", n), tick_bit, (n % 16) == 0);
            checkOutput($sformatf("default clk_out %0d", n), clk_out, (n % 16) >= 8);
        end

        // Mid-period load of 4/0: current period completes, then every 4 cycles.
        resetDut();
        en = 1'b1;
        waitTick(100, cyc);
        checkOutput("load first period", cyc, 27);
        repeat (10) stepCycle();
        div_int  = 16'd4;
        div_frac = 4'd0;
        div_load = 1'b1;
        stepCycle();
        div_load = 1'b0;
        checkOutput("valid load div_err", div_err, 0);
        waitTick(100, cyc);
        checkOutput("load period not truncated", cyc + 11, expPeriod(2, 2, 27));
        for (int k = 0; k < 5; k++) begin
            waitTick(100, cyc);
            checkOutput($sformatf("loaded period %0d", k), cyc, 4);
        end

        // Illegal loads of 1 and 0 pulse div_err once and leave the period alone.
        resetDut();
        en = 1'b1;
        repeat (5) stepCycle();
        div_int  = 16'd1;
        div_frac = 4'd3;
        div_load = 1'b1;
        stepCycle();
        div_load = 1'b0;
        checkOutput("err on div 1", div_err, 1);
        stepCycle();
        checkOutput("err clears after 1", div_err, 0);
        div_int  = 16'd0;
        div_load = 1'b1;
        stepCycle();
        div_load = 1'b0;
        checkOutput("err on div 0", div_err, 1);
        stepCycle();
        checkOutput("err clears after 0", div_err, 0);
        waitTick(100, cyc);
        checkOutput("illegal first period", cyc + 9, 27);
        for (int p = 2; p <= 4; p++) begin
            waitTick(100, cyc);
            checkOutput($sformatf("illegal period %0d", p), cyc, expPeriod(p, 2, 27));
        end

        // Phase clear at oscnt 9: square wave drops, ticks restart from the clear.
        resetDut();
        en = 1'b1;
        repeat (9) waitTick(100, cyc);
        repeat (3) stepCycle();
        checkOutput("clk_out high before clear", clk_out, 1);
        phase_clr = 1'b1;
        stepCycle();
        phase_clr = 1'b0;
        checkOutput("clk_out after clear", clk_out, 0);
        checkOutput("tick_os after clear", tick_os, 0);
        first_os  = 0;
        first_bit = 0;
        cnt       = 0;
        while (first_bit == 0 && cnt < 1000) begin
            stepCycle();
            cnt++;
            if (tick_os === 1'b1 && first_os == 0)
                first_os = cnt;
            if (tick_bit === 1'b1)
                first_bit = cnt;
        end
        total = 0;
        for (int p = 1; p <= 16; p++)
            total += expPeriod(p, 2, 27);
        checkOutput("first tick_os after clear", first_os, 27);
        checkOutput("first tick_bit after clear", first_bit, total);

        // Enable freeze at pcnt 5 for 50 cycles.
        resetDut();
        en = 1'b1;
        waitTick(100, cyc);
        repeat (5) stepCycle();
        en   = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            stepCycle();
            if (tick_os !== 1'b0 || tick_bit !== 1'b0)
                seen = 1'b1;
        end
        checkOutput("no ticks while frozen", seen, 0);
        en = 1'b1;
        waitTick(100, cyc);
        checkOutput("frozen period enabled cycles", cyc + 5, expPeriod(2, 2, 27));

        // Clear with simultaneous load of 27/8 applies directly.
        resetDut();
        en = 1'b1;
        repeat (7) stepCycle();
        div_int   = 16'd27;
        div_frac  = 4'd8;
        div_load  = 1'b1;
        phase_clr = 1'b1;
        stepCycle();
        div_load  = 1'b0;
        phase_clr = 1'b0;
        for (int p = 1; p <= 8; p++) begin
            waitTick(100, cyc);
            checkOutput($sformatf("frac8 period %0d", p), cyc, expPeriod(p, 8, 27));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
